// File: rtl/p4s1_4buf.sv
// p4s1_4buf: parallel-to-serial stage that sits after the FFT-1024 1:4
// serial-to-parallel block.
//
// Each in_valid strobe carries one 4-word group, which goes into a two-entry
// group buffer. Groups are sent out one word per pop on a valid/ready stream.
// The oldest sample (data_in3) goes first, so the original sample order comes
// back. Frame start/end flags mark FRAME_LEN-sample frames. The upstream stage
// cannot be stalled, so a group that arrives when the buffer is full is
// dropped and the sticky overflow flag is set.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   one-cycle strobe, data_in0..3 hold a complete group
//   data_in0   newest sample of the group
//   data_in1   second-newest sample
//   data_in2   second-oldest sample
//   data_in3   oldest sample
//   in_ready   buffer holds fewer than two groups (status only)
//   out_valid  data_out holds a valid sample
//   out_ready  downstream accepts data_out this cycle
//   data_out   serial sample (0 when out_valid is low)
//   out_sop    first sample of a frame
//   out_eop    last sample of a frame
//   overflow   sticky flag, a group was dropped
//   ovf_clr    synchronous clear of overflow (a simultaneous drop wins)
module p4s1_4buf #(
    parameter int WORDLENGTH = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int CNT_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WORDLENGTH-1:0] data_in0,
    input  logic [WORDLENGTH-1:0] data_in1,
    input  logic [WORDLENGTH-1:0] data_in2,
    input  logic [WORDLENGTH-1:0] data_in3,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORDLENGTH-1:0] data_out,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    // Control state
    logic [1:0]       count_reg;
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       word_idx_reg;
    logic [CNT_W-1:0] sample_cnt_reg;
    logic             overflow_reg;

    logic [1:0]       count_next;

    // Input words packed by position, and the words of the head group
    logic [3:0][WORDLENGTH-1:0] din;
    logic [3:0][WORDLENGTH-1:0] head_words;

    logic pop;
    logic group_done;
    logic wr_accept;
    logic wr_drop;

    assign din = {data_in3, data_in2, data_in1, data_in0};

    assign out_valid  = (count_reg != 2'd0);
    assign pop        = out_valid && out_ready;
    assign group_done = pop && (word_idx_reg == 2'd3);

    // A full buffer can still take a group when the head group is freed on
    // the same edge, so there is no bubble at full throughput.
    assign wr_accept = in_valid && ((count_reg < 2'd2) || group_done);
    assign wr_drop   = in_valid && !wr_accept;

    always_comb begin
        count_next = count_reg;
        if (wr_accept && !group_done) begin
            count_next = count_reg + 2'd1;
        end else if (!wr_accept && group_done) begin
            count_next = count_reg - 2'd1;
        end
    end

    // Group storage. Each word position is a pair of registers, one per
    // buffer entry. Only the write-enabled entry changes, so no reset is
    // needed: data_out is masked while the buffer is empty.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            logic [WORDLENGTH-1:0] word_mem [2];

            always_ff @(posedge clk) begin
                if (wr_accept) begin
                    word_mem[wr_ptr_reg] <= din[gi];
                end
            end

            assign head_words[gi] = word_mem[rd_ptr_reg];
        end
    endgenerate

    // Control path. Count, pointers and word index all update on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg      <= 2'd0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            word_idx_reg   <= 2'd0;
            sample_cnt_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (wr_accept) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                // The 2-bit index wraps from 3 to 0 on the group-done pop.
                word_idx_reg <= word_idx_reg + 2'd1;
                if (sample_cnt_reg == CNT_W'(FRAME_LEN - 1)) begin
                    sample_cnt_reg <= '0;
                end else begin
                    sample_cnt_reg <= sample_cnt_reg + 1'b1;
                end
            end
            if (group_done) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            // A drop wins over a simultaneous clear.
            if (wr_drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Outputs are driven only from registers through a mux. Word 3 (the
    // oldest) is sent first.
    assign data_out = out_valid ? head_words[2'd3 - word_idx_reg] : '0;
    assign out_sop  = out_valid && (sample_cnt_reg == '0);
    assign out_eop  = out_valid && (sample_cnt_reg == CNT_W'(FRAME_LEN - 1));
    assign in_ready = (count_reg < 2'd2);
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_p4s1_4buf.sv
module tb_p4s1_4buf;

    localparam int W         = 16;
    localparam int FRAME_LEN = 1024;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] data_in0;
    logic [W-1:0] data_in1;
    logic [W-1:0] data_in2;
    logic [W-1:0] data_in3;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic         out_sop;
    logic         out_eop;
    logic         overflow;
    logic         ovf_clr;

    p4s1_4buf #(.WORDLENGTH(W), .FRAME_LEN(FRAME_LEN), .CNT_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_in3  (data_in3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: a queue of words still to be output, in output
    // order, a count of all pops modulo FRAME_LEN, and the overflow flag.
    logic [W-1:0] mq[$];
    int           mcnt = 0;
    bit           movf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        int groups;
        groups = (mq.size() + 3) / 4;
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("data_out",  32'(data_out),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("out_sop",   32'(out_sop),   32'(mq.size() != 0 && mcnt == 0));
        chk("out_eop",   32'(out_eop),   32'(mq.size() != 0 && mcnt == FRAME_LEN - 1));
        chk("in_ready",  32'(in_ready),  32'(groups < 2));
        chk("overflow",  32'(overflow),  32'(movf));
    endtask

    // One clock cycle: drive inputs, update the model for the coming edge,
    // then check the outputs on the following falling edge.
    task automatic step(input bit iv, input logic [W-1:0] d3, input logic [W-1:0] d2,
                        input logic [W-1:0] d1, input logic [W-1:0] d0,
                        input bit ordy, input bit clr);
        bit pop, gd, acc;
        int groups;
        in_valid  = iv;
        data_in3  = d3;
        data_in2  = d2;
        data_in1  = d1;
        data_in0  = d0;
        out_ready = ordy;
        ovf_clr   = clr;
        pop    = (mq.size() != 0) && ordy;
        // The head group is freed when only its last word is left.
        gd     = pop && (mq.size() % 4 == 1);
        groups = (mq.size() + 3) / 4;
        acc    = iv && (groups < 2 || gd);
        @(posedge clk);
        if (pop) begin
            void'(mq.pop_front());
            mcnt = (mcnt + 1) % FRAME_LEN;
        end
        if (acc) begin
            mq.push_back(d3);
            mq.push_back(d2);
            mq.push_back(d1);
            mq.push_back(d0);
        end
        if (iv && !acc) movf = 1'b1;
        else if (clr)   movf = 1'b0;
        @(negedge clk);
        model_check();
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, ordy, 1'b0);
    endtask

    task automatic grp(input logic [W-1:0] base, input bit ordy, input bit clr);
        step(1'b1, base, base + 16'd1, base + 16'd2, base + 16'd3, ordy, clr);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && mq.size() != 0; k++) idle(1'b1);
        chk("drain_empty", 32'(out_valid), 32'd0);
    endtask

    // Assert reset away from a clock edge and check the outputs before
    // the next edge arrives.
    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out",  32'(data_out),  32'd0);
        chk("rst_out_sop",   32'(out_sop),   32'd0);
        chk("rst_out_eop",   32'(out_eop),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_overflow",  32'(overflow),  32'd0);
        mq.delete();
        mcnt = 0;
        movf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp8 [8];
        int sop_seen, eop_seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
        #2;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_in_ready",  32'(in_ready),  32'd1);
        chk("init_overflow",  32'(overflow),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single group after reset, out_ready high.
        step(1'b1, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 1'b1, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_s0",    32'(data_out),  32'h4);
        chk("t1_sop",   32'(out_sop),   32'd1);
        idle(1'b1); chk("t1_s1", 32'(data_out), 32'h3);
        idle(1'b1); chk("t1_s2", 32'(data_out), 32'h2);
        idle(1'b1); chk("t1_s3", 32'(data_out), 32'h1);
        idle(1'b1); chk("t1_done", 32'(out_valid), 32'd0);

        // Continuous stream: 257 groups, one every 4 cycles, value = index.
        do_reset();
        sop_seen = 0; eop_seen = 0;
        for (int g = 0; g < 257; g++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) grp(16'(4 * g), 1'b1, 1'b0);
                else        idle(1'b1);
                chk("stream_nogap", 32'(out_valid), 32'd1);
                if (out_sop) begin
                    chk("stream_sop_val", 32'(data_out), 32'(sop_seen * FRAME_LEN));
                    sop_seen++;
                end
                if (out_eop) begin
                    chk("stream_eop_val", 32'(data_out), 32'(FRAME_LEN - 1));
                    eop_seen++;
                end
            end
        end
        chk("stream_sop_cnt", 32'(sop_seen), 32'd2);
        chk("stream_eop_cnt", 32'(eop_seen), 32'd1);
        chk("stream_ovf",     32'(overflow), 32'd0);
        drain();

        // Back-pressure: three groups with out_ready low, third is dropped.
        grp(16'h1100, 1'b0, 1'b0);
        grp(16'h2200, 1'b0, 1'b0);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        grp(16'h3300, 1'b0, 1'b0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        exp8 = '{16'h1100, 16'h1101, 16'h1102, 16'h1103,
                 16'h2200, 16'h2201, 16'h2202, 16'h2203};
        for (int i = 0; i < 8; i++) begin
            chk("t3_sample", 32'(data_out), 32'(exp8[i]));
            idle(1'b1);
        end
        chk("t3_empty", 32'(out_valid), 32'd0);

        // ovf_clr alone.
        step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("t8_ovf_clr", 32'(overflow), 32'd0);

        // Full buffer, head group's last word pops while a new group arrives.
        grp(16'h4400, 1'b0, 1'b0);
        grp(16'h5500, 1'b0, 1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1);
        grp(16'h6600, 1'b1, 1'b0);
        chk("t4_count2", 32'(in_ready), 32'd0);
        chk("t4_no_ovf", 32'(overflow), 32'd0);
        drain();

        // out_ready toggling during a group.
        grp(16'h7700, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) idle(i % 2 == 0);
        drain();

        // Reset mid-frame with two groups buffered.
        grp(16'h8800, 1'b1, 1'b0);
        grp(16'h9900, 1'b0, 1'b0);
        do_reset();
        grp(16'hAA00, 1'b1, 1'b0);
        chk("t6_sop",  32'(out_sop),  32'd1);
        chk("t6_data", 32'(data_out), 32'hAA00);
        drain();

        // Drop coinciding with ovf_clr: set wins.
        grp(16'hBB00, 1'b0, 1'b0);
        grp(16'hCC00, 1'b0, 1'b0);
        grp(16'hDD00, 1'b0, 1'b1);
        chk("t7_set_wins", 32'(overflow), 32'd1);
        step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 3) == 0, 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), ($urandom % 4) != 0, ($urandom % 8) == 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
